// File: rtl/counter_load_multi.sv
// counter_load_multi: loadable up/down counter with step, limits, wrap/saturate/one-shot modes,
// terminal-count pulse and sticky limit flags.
module counter_load_multi #(
    parameter int WIDTH = 8,
    parameter int STEP_W = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              up_down,
    input  logic              en,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  lo_lim,
    input  logic [WIDTH-1:0]  hi_lim,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              done
);
    typedef enum logic {ST_ARMED, ST_DONE} state_t;
    state_t state;
    logic [WIDTH:0] step_x, sum, diff;
    logic [WIDTH-1:0] tgt, nxt;
    logic cnt, ev_hi, ev_lo, ev, clamp, oneshot, hold;
    assign step_x = {{(WIDTH+1-STEP_W){1'b0}}, step};
    assign sum = {1'b0, data_out} + step_x;
    assign diff = {1'b0, data_out} - step_x;
    assign done = state == ST_DONE;
    always_comb begin
        cnt = en & ~load & (state == ST_ARMED) & (step != '0);
        ev_hi = cnt & up_down & (sum > {1'b0, hi_lim});
        // diff[WIDTH] set means the subtraction went negative
        ev_lo = cnt & ~up_down & (diff[WIDTH] | (diff[WIDTH-1:0] < lo_lim));
        ev = ev_hi | ev_lo;
        oneshot = mode == 2'd2;
        clamp = (mode == 2'd1) | oneshot;
        tgt = (ev_hi == clamp) ? hi_lim : lo_lim;
        hold = (mode == 2'd1) & (data_out == tgt);
        nxt = ev ? tgt : (up_down ? sum[WIDTH-1:0] : diff[WIDTH-1:0]);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= RST_VAL;
            tc <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
            state <= ST_ARMED;
        end else begin
            ovf <= (ovf & ~clr_flags) | ev_hi;
            unf <= (unf & ~clr_flags) | ev_lo;
            tc <= ev & ~hold;
            if (load) begin
                data_out <= data_in;
                state <= ST_ARMED;
            end else if (state == ST_DONE) begin
                if (!oneshot) state <= ST_ARMED;
            end else if (cnt) begin
                data_out <= nxt;
                if (ev && oneshot) state <= ST_DONE;
            end
        end
    end
endmodule

// File: tb/tb_counter_load_multi.sv
// tb_counter_load_multi: directed-vector bench for counter_load_multi (WIDTH=8, STEP_W=4).
module tb_counter_load_multi;
    logic clk = 1'b0;
    logic rst, load, up_down, en, clr_flags;
    logic [7:0] data_in, lo_lim, hi_lim, data_out;
    logic [3:0] step;
    logic [1:0] mode;
    logic tc, ovf, unf, done;
    int cmp = 0;
    int errs = 0;

    counter_load_multi #(.WIDTH(8), .STEP_W(4), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .up_down(up_down),
        .en(en), .step(step), .mode(mode), .lo_lim(lo_lim), .hi_lim(hi_lim),
        .clr_flags(clr_flags), .data_out(data_out), .tc(tc), .ovf(ovf),
        .unf(unf), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] d, input logic t,
                           input logic o, input logic u, input logic dn);
        chk({name, ".data"}, 32'(data_out), 32'(d));
        chk({name, ".tc"}, 32'(tc), 32'(t));
        chk({name, ".ovf"}, 32'(ovf), 32'(o));
        chk({name, ".unf"}, 32'(unf), 32'(u));
        chk({name, ".done"}, 32'(done), 32'(dn));
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; up_down = 1'b1; en = 1'b0; clr_flags = 1'b0;
        data_in = 8'd0; lo_lim = 8'd0; hi_lim = 8'd255; step = 4'd1; mode = 2'd0;
        #2;
        chk_all("reset", 8'd0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        // raise ovf, then count from 0x37 and reset asynchronously mid-count
        load = 1'b1; data_in = 8'hFF; tick();
        load = 1'b0; en = 1'b1; tick();
        chk_all("pre_wrap", 8'd0, 1, 1, 0, 0);
        en = 1'b0; load = 1'b1; data_in = 8'h37; tick();
        load = 1'b0; en = 1'b1; tick();
        chk_all("count_38", 8'h38, 0, 1, 0, 0);
        #2 rst = 1'b0;
        #1 chk_all("async_rst", 8'd0, 0, 0, 0, 0);
        tick();
        chk_all("rst_hold", 8'd0, 0, 0, 0, 0);
        rst = 1'b1; en = 1'b0;
        // wrap up
        mode = 2'd0; lo_lim = 8'd10; hi_lim = 8'd20; step = 4'd3; up_down = 1'b1;
        load = 1'b1; data_in = 8'd18; tick();
        load = 1'b0;
        chk_all("wrap_load", 8'd18, 0, 0, 0, 0);
        en = 1'b1; tick();
        chk_all("wrap_ev", 8'd10, 1, 1, 0, 0);
        tick(); chk_all("wrap_13", 8'd13, 0, 1, 0, 0);
        tick(); chk_all("wrap_16", 8'd16, 0, 1, 0, 0);
        en = 1'b0; clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk_all("clr_ovf", 8'd16, 0, 0, 0, 0);
        // saturate down
        mode = 2'd1; lo_lim = 8'd5; hi_lim = 8'd200; step = 4'd4; up_down = 1'b0;
        load = 1'b1; data_in = 8'd7; tick(); load = 1'b0;
        en = 1'b1; tick();
        chk_all("sat_ev", 8'd5, 1, 0, 1, 0);
        tick(); chk_all("sat_hold1", 8'd5, 0, 0, 1, 0);
        tick(); chk_all("sat_hold2", 8'd5, 0, 0, 1, 0);
        en = 1'b0; clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk_all("clr_alone", 8'd5, 0, 0, 0, 0);
        // one-shot up
        mode = 2'd2; lo_lim = 8'd0; hi_lim = 8'd9; step = 4'd1; up_down = 1'b1;
        load = 1'b1; data_in = 8'd7; tick(); load = 1'b0;
        en = 1'b1; tick();
        chk_all("os_8", 8'd8, 0, 0, 0, 0);
        tick(); chk_all("os_9", 8'd9, 0, 0, 0, 0);
        tick(); chk_all("os_ev", 8'd9, 1, 1, 0, 1);
        tick(); chk_all("os_done_hold", 8'd9, 0, 1, 0, 1);
        load = 1'b1; data_in = 8'd2; tick(); load = 1'b0;
        chk_all("os_reload", 8'd2, 0, 1, 0, 0);
        // leaving DONE through a mode change
        load = 1'b1; data_in = 8'd9; tick(); load = 1'b0;
        tick(); chk_all("os_done2", 8'd9, 1, 1, 0, 1);
        mode = 2'd0; tick();
        chk_all("mode_exit", 8'd9, 0, 1, 0, 0);
        tick(); chk_all("wrap_after", 8'd0, 1, 1, 0, 0);
        // load beats a would-be event
        en = 1'b0; clr_flags = 1'b1; mode = 2'd0; lo_lim = 8'd10; hi_lim = 8'd20; step = 4'd3;
        load = 1'b1; data_in = 8'd19; tick(); clr_flags = 1'b0;
        chk_all("ld19", 8'd19, 0, 0, 0, 0);
        en = 1'b1; data_in = 8'd12; tick(); load = 1'b0; en = 1'b0;
        chk_all("load_prio", 8'd12, 0, 0, 0, 0);
        // clr_flags and ev_hi on the same edge
        load = 1'b1; data_in = 8'd19; tick(); load = 1'b0;
        en = 1'b1; clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk_all("clr_vs_set", 8'd10, 1, 1, 0, 0);
        // step zero freezes the value
        step = 4'd0; tick();
        chk_all("step0_a", 8'd10, 0, 1, 0, 0);
        tick(); chk_all("step0_b", 8'd10, 0, 1, 0, 0);
        // out-of-range load then wrap
        en = 1'b0; step = 4'd1; clr_flags = 1'b1; load = 1'b1; data_in = 8'd250; tick();
        load = 1'b0; clr_flags = 1'b0;
        chk_all("ld250", 8'd250, 0, 0, 0, 0);
        en = 1'b1; tick();
        chk_all("oor_wrap", 8'd10, 1, 1, 0, 0);
        en = 1'b0; tick();
        chk_all("en0", 8'd10, 0, 1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/counter_load_multi.md
Name: counter_load_multi

Overview:
- Parametrised successor to the team's loadable up/down counter.
- Adds:
  - width and step generalisation
  - programmable lower and upper limits
  - three count modes: wrap, saturate and one-shot
  - a terminal-count pulse
  - sticky overflow and underflow flags
- Drop-in replacement wherever a loadable up/down counter is used.
- Verified through the same class-based interface and testbench flow.

Parameters:
- WIDTH, 8: counter, data and limit width in bits.
- STEP_W, 4: step input width. Must be less than or equal to WIDTH.
- RST_VAL, 0: data_out value on reset, WIDTH bits.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 resets immediately.
- load  input  1  synchronous load of data_in.
- data_in  input  WIDTH  load value.
- up_down  input  1  count direction: 1 = up, 0 = down.
- en  input  1  count enable.
- step  input  STEP_W  increment or decrement amount per enabled cycle.
- mode  input  2  count mode: 0 = wrap, 1 = saturate, 2 = one-shot, 3 = reserved (behaves as wrap).
- lo_lim  input  WIDTH  lower count limit.
- hi_lim  input  WIDTH  upper count limit.
- clr_flags  input  1  synchronous clear of ovf and unf.
- data_out  output  WIDTH  counter value, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- ovf  output  1  sticky upper-limit event flag.
- unf  output  1  sticky lower-limit event flag.
- done  output  1  one-shot finished; equals 1 exactly when the FSM is in DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=RST_VAL; tc=0, ovf=0, unf=0, done=0; FSM=ARMED.
  - Takes effect mid-operation without waiting for a clock edge.
  - Release is synchronous to the next clk edge.
- Priority per edge: load > count. clr_flags is evaluated independently of load and count.
- Load:
  - data_out <= data_in; FSM <= ARMED; tc <= 0.
  - No clamping to the limits; an out-of-range value is accepted.
- Count occurs when en=1, load=0 and FSM=ARMED. Arithmetic is in WIDTH+1 bits with step zero-extended:
  - up: sum = data_out + step. Upper boundary event (ev_hi) when sum > hi_lim.
  - down: diff = data_out - step, signed. Lower boundary event (ev_lo) when diff < lo_lim, including a negative diff.
  - With no event, data_out <= sum or diff truncated to WIDTH bits.
- Response to a boundary event, by mode:
  - wrap: ev_hi -> data_out <= lo_lim; ev_lo -> data_out <= hi_lim. No modular remainder is carried.
  - saturate: ev_hi -> data_out <= hi_lim; ev_lo -> data_out <= lo_lim.
  - one-shot: clamp as in saturate, then FSM <= DONE.
- tc:
  - Set to 1 for one cycle on the edge following any boundary event.
  - Exception: in saturate mode, when data_out already equals the clamp target, tc stays 0 and the value holds.
- ovf is set on ev_hi; unf is set on ev_lo. Both stay set until clr_flags=1 or reset.
- clr_flags and a new event on the same edge: set wins, and the flag is 1.
- step=0: no value change and no event.
- en=0: data_out holds; tc=0.
- FSM states: ARMED and DONE.
  - ARMED -> DONE: boundary event while mode=2.
  - DONE -> ARMED: load=1, or mode != 2 sampled at an edge.
  - In DONE, data_out holds regardless of en.
- mode, limit and step changes take effect at the next edge using the current input values. No internal shadowing.
- lo_lim > hi_lim is an illegal configuration. Behaviour is unspecified and benches must not drive it.
- Latency: every output changes one edge after the causing inputs, except on asynchronous reset.

Test Plan (WIDTH=8, STEP_W=4):
- Async reset mid-count: data_out=0x37 with en=1; drive rst=0 between edges -> data_out=0, flags 0 before the next edge; hold rst=0 -> stays 0.
- Wrap up: lo=10, hi=20, step=3, load 18, up, en -> 18, then 10 (21 > 20), tc=1 for that one cycle, ovf=1 -> then 13, 16, with ovf still 1.
- Saturate down: lo=5, hi=200, step=4, load 7, down -> 5 with tc=1, unf=1 -> next edges hold 5 with tc=0.
- One-shot up: lo=0, hi=9, step=1, load 7 -> 8, 9, then event: data_out=9, done=1, tc pulse -> en held high keeps 9 -> load 2 gives 2 with done=0.
- Simultaneous events:
  - load=1 and en=1 with a would-be event -> data_out=data_in, no tc, no flag change.
  - clr_flags=1 on the same edge as an ev_hi -> ovf=1.
  - clr_flags alone -> ovf=0, unf=0.
- Edge cases:
  - step=0 with en=1 -> value frozen, tc=0.
  - Load 250 with hi=20, up, step=1, wrap -> 10 (lo=10), tc=1, ovf=1.
